icache_data_array_nway: RTL

//  N-way instruction-cache data array with a burst refill engine. Accepts one

---
 rtl/icache_data_array_nway_pkg.sv | 17 +
 rtl/icache_data_way_ram.sv | 30 +++
 rtl/icache_data_array_nway.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/icache_data_array_nway_pkg.sv
// Shared types and default geometry for the instruction-cache data array.
package icache_data_array_nway_pkg;

  localparam int unsigned DefWays        = 2;
  localparam int unsigned DefIndexWidth  = 7;
  localparam int unsigned DefOffsetWidth = 5;
  localparam int unsigned DefBankWidth   = 32;
  localparam int unsigned DefBankNum     = 8;

  // Refill engine: idle, collecting beats, committing the line.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StWrite = 2'd2
  } fill_state_e;

endpackage

// File: rtl/icache_data_way_ram.sv
// One way of line storage: single port, synchronous read, whole-line write.
module icache_data_way_ram #(
  parameter int unsigned IndexWidth = 7,
  parameter int unsigned LineWidth  = 256
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [IndexWidth-1:0] addr_i,
  input  logic [LineWidth-1:0]  wdata_i,
  output logic [LineWidth-1:0]  rdata_o
);

  logic [LineWidth-1:0] mem_q [2**IndexWidth];
  logic [LineWidth-1:0] rdata_q;

  // Storage is not reset; output holds the last read until the next access.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/icache_data_array_nway.sv
// N-way icache data array: 1-cycle fetch reads with late way select, plus a
// burst refill engine that buffers a line, forwards buffered words, and commits.
module icache_data_array_nway
  import icache_data_array_nway_pkg::*;
#(
  parameter int unsigned Ways        = DefWays,
  parameter int unsigned IndexWidth  = DefIndexWidth,
  parameter int unsigned OffsetWidth = DefOffsetWidth,
  parameter int unsigned BankWidth   = DefBankWidth,
  parameter int unsigned BankNum     = DefBankNum
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rd_en_i,
  output logic                   rd_ready_o,
  input  logic [IndexWidth-1:0]  rd_index_i,
  input  logic [OffsetWidth-1:0] rd_offset_i,
  input  logic [Ways-1:0]        rd_hit_way_i,
  output logic                   rd_valid_o,
  output logic                   rd_fwd_o,
  output logic [BankWidth-1:0]   rd_rdata_o,
  input  logic                   refill_start_i,
  input  logic [IndexWidth-1:0]  refill_index_i,
  input  logic [Ways-1:0]        refill_way_i,
  input  logic                   refill_beat_valid_i,
  input  logic [BankWidth-1:0]   refill_beat_data_i,
  output logic                   refill_busy_o,
  output logic                   refill_done_o
);

  localparam int unsigned LineW = BankNum * BankWidth;
  localparam int unsigned SelW  = OffsetWidth - 2;

  fill_state_e           state_q, state_d;
  logic [IndexWidth-1:0] fill_idx_q, fill_idx_d;
  logic [Ways-1:0]       fill_way_q, fill_way_d;
  logic [SelW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [BankNum-1:0]    mask_q, mask_d;
  logic                  done_q, done_d;
  logic [BankWidth-1:0]  buf_q [BankNum];

  logic                  rd_req_q, rd_req_d;
  logic                  fwd_q, fwd_d;
  logic [SelW-1:0]       word_sel_q, word_sel_d;
  logic [BankWidth-1:0]  fwd_data_q;

  logic                  rd_acc;
  logic                  fill_idx_match;
  logic [SelW-1:0]       rd_word;
  logic                  ram_rd;
  logic [IndexWidth-1:0] ram_addr;
  logic [LineW-1:0]      wline;
  logic [LineW-1:0]      ram_rdata [Ways];
  logic [BankWidth-1:0]  way_word [Ways];

  // Byte-within-word offset bits carry no meaning for word reads.
  logic unused_offset;
  assign unused_offset = ^rd_offset_i[1:0];

  assign rd_ready_o     = (state_q != StWrite);
  assign refill_busy_o  = (state_q != StIdle);
  assign refill_done_o  = done_q;
  assign rd_acc         = rd_en_i & rd_ready_o;
  assign rd_word        = rd_offset_i[OffsetWidth-1:2];
  assign fill_idx_match = (state_q == StFill) && (rd_index_i == fill_idx_q);
  // A read hitting the line under refill is served from the buffer or dropped.
  assign ram_rd         = rd_acc & ~fill_idx_match;
  assign ram_addr       = (state_q == StWrite) ? fill_idx_q : rd_index_i;

  // Refill FSM next state: capture target, count beats, one-cycle commit.
  always_comb begin
    state_d    = state_q;
    fill_idx_d = fill_idx_q;
    fill_way_d = fill_way_q;
    beat_cnt_d = beat_cnt_q;
    mask_d     = mask_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (refill_start_i) begin
          state_d    = StFill;
          fill_idx_d = refill_index_i;
          fill_way_d = refill_way_i;
          beat_cnt_d = '0;
          mask_d     = '0;
        end
      end
      StFill: begin
        if (refill_beat_valid_i) begin
          mask_d[beat_cnt_q] = 1'b1;
          beat_cnt_d         = beat_cnt_q + SelW'(1);
          if (beat_cnt_q == SelW'(BankNum - 1)) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Refill FSM and control registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      fill_idx_q <= '0;
      fill_way_q <= '0;
      beat_cnt_q <= '0;
      mask_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_idx_q <= fill_idx_d;
      fill_way_q <= fill_way_d;
      beat_cnt_q <= beat_cnt_d;
      mask_q     <= mask_d;
      done_q     <= done_d;
    end
  end

  // Line buffer and forwarded word are pure datapath, validity lives in mask/fwd.
  always_ff @(posedge clk_i) begin
    if (state_q == StFill && refill_beat_valid_i) begin
      buf_q[beat_cnt_q] <= refill_beat_data_i;
    end
    if (rd_acc) begin
      fwd_data_q <= buf_q[rd_word];
    end
  end

  // Read pipeline next state.
  always_comb begin
    rd_req_d   = ram_rd;
    fwd_d      = rd_acc & fill_idx_match & mask_q[rd_word];
    word_sel_d = rd_acc ? rd_word : word_sel_q;
  end

  // Read pipeline registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_req_q   <= 1'b0;
      fwd_q      <= 1'b0;
      word_sel_q <= '0;
    end else begin
      rd_req_q   <= rd_req_d;
      fwd_q      <= fwd_d;
      word_sel_q <= word_sel_d;
    end
  end

  // Pack the buffer: word k sits at the top end minus k words.
  always_comb begin
    wline = '0;
    for (int k = 0; k < BankNum; k++) begin
      wline[LineW-1-k*BankWidth -: BankWidth] = buf_q[k];
    end
  end

  for (genvar g = 0; g < Ways; g++) begin : g_way
    icache_data_way_ram #(
      .IndexWidth(IndexWidth),
      .LineWidth (LineW)
    ) u_ram (
      .clk_i  (clk_i),
      .en_i   (ram_rd | ((state_q == StWrite) & fill_way_q[g])),
      .we_i   ((state_q == StWrite) & fill_way_q[g]),
      .addr_i (ram_addr),
      .wdata_i(wline),
      .rdata_o(ram_rdata[g])
    );
  end

  // Pick the requested word out of each way's line.
  always_comb begin
    for (int w = 0; w < Ways; w++) begin
      way_word[w] = '0;
      for (int k = 0; k < BankNum; k++) begin
        if (word_sel_q == SelW'(k)) begin
          way_word[w] = ram_rdata[w][LineW-1-k*BankWidth -: BankWidth];
        end
      end
    end
  end

  // Late way select; a zero hit vector yields zero data.
  always_comb begin
    rd_rdata_o = '0;
    if (fwd_q) begin
      rd_rdata_o = fwd_data_q;
    end else if (rd_req_q) begin
      for (int w = 0; w < Ways; w++) begin
        if (rd_hit_way_i[w]) begin
          rd_rdata_o = rd_rdata_o | way_word[w];
        end
      end
    end
  end

  assign rd_valid_o = rd_req_q | fwd_q;
  assign rd_fwd_o   = fwd_q;

endmodule
